// File: rtl/tf_pkg.sv
// Shared constants, FSM state type and lane helper for the twiddle-factor fetch path.
package tf_pkg;
  localparam int LANE_W = 14;
  localparam int LANES  = 4;
  localparam int DATA_W = LANE_W * LANES;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 383;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tf_state_t;

  // Lane idx of a packed word; lane 0 sits in the least significant bits.
  function automatic logic [LANE_W-1:0] lane(input logic [DATA_W-1:0] w, input int unsigned idx);
    return w[idx*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/tf_fifo4.sv
// 4-entry synchronous FIFO with occupancy count; push while full is accepted only with a pop.
module tf_fifo4 #(
  parameter int W = tf_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [2:0]   count,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end
endmodule

// File: rtl/tf_fetch.sv
// Streams count twiddle words from the RAM starting at base (wrapping at DEPTH) onto a valid/ready port.
module tf_fetch #(
  parameter int ADDR_W = tf_pkg::ADDR_W,
  parameter int DATA_W = tf_pkg::DATA_W,
  parameter int DEPTH  = tf_pkg::DEPTH,
  parameter int CNT_W  = tf_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_A,
  output logic [DATA_W-1:0] rom_D,
  output logic              rom_EN,
  output logic              rom_REN,
  input  logic [DATA_W-1:0] rom_Q,
  output logic [DATA_W-1:0] tf_data,
  output logic              tf_valid,
  input  logic              tf_ready,
  output logic [1:0]        state
);
  import tf_pkg::*;

  // Stream port: a word moves on every rising edge where tf_valid && tf_ready;
  // tf_valid never depends on tf_ready, and tf_data holds until accepted.

  tf_state_t         st;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  issued;
  logic [ADDR_W-1:0] next_addr;
  logic              rd_flag;
  logic [2:0]        fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        inflight;
  logic              pop;
  logic              credit;
  logic              drained;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign rom_D    = '0;
  assign rom_REN  = 1'b1;
  assign state    = st;
  assign tf_valid = !fifo_empty;
  assign pop      = tf_valid && tf_ready;

  // A read is in flight from the cycle rom_EN is high until rd_flag pushes its data.
  assign inflight = {1'b0, rom_EN} + {1'b0, rd_flag};
  assign credit   = !fifo_full && ((fifo_cnt + {1'b0, inflight}) < 3'd4);
  assign drained  = !rom_EN && !rd_flag &&
                    ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop));

  tf_fifo4 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_flag),
    .pop   (pop),
    .din   (rom_Q),
    .dout  (tf_data),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_EN    <= 1'b0;
      rom_A     <= '0;
      rd_flag   <= 1'b0;
      cnt_q     <= '0;
      issued    <= '0;
      next_addr <= '0;
    end else begin
      done    <= 1'b0;
      rom_EN  <= 1'b0;
      // rom_Q is fresh only the cycle after a read; the RAM holds its output otherwise.
      rd_flag <= rom_EN;
      case (st)
        IDLE: begin
          if (start) begin
            cnt_q <= count;
            if (count != '0) begin
              st        <= RUN;
              busy      <= 1'b1;
              rom_EN    <= 1'b1;
              rom_A     <= base;
              next_addr <= wrap_inc(base);
              issued    <= CNT_W'(1);
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued == cnt_q) begin
            st <= DRAIN;
          end else if (credit) begin
            rom_EN    <= 1'b1;
            rom_A     <= next_addr;
            next_addr <= wrap_inc(next_addr);
            issued    <= issued + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drained) begin
            st   <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tf_fetch.sv
// Directed bench for tf_fetch: behavioural 1-cycle-latency RAM, per-scenario tasks, expected values from RAM contents.
module tb_tf_fetch;
  import tf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base;
  logic [9:0]  count;
  logic        busy;
  logic        done;
  logic [8:0]  rom_A;
  logic [55:0] rom_D;
  logic        rom_EN;
  logic        rom_REN;
  logic [55:0] rom_Q;
  logic [55:0] tf_data;
  logic        tf_valid;
  logic        tf_ready;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  logic [55:0] ram [0:511];

  logic [55:0] got_q[$];
  int          got_t[$];
  logic [8:0]  addr_q[$];
  int          en_cnt;
  int          max_out;
  int          done_t;
  logic        busy_t1;
  logic        busy_at_done;
  logic [1:0]  state_t2;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_EN) rom_Q <= ram[rom_A];

  tf_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rom_A    (rom_A),
    .rom_D    (rom_D),
    .rom_EN   (rom_EN),
    .rom_REN  (rom_REN),
    .rom_Q    (rom_Q),
    .tf_data  (tf_data),
    .tf_valid (tf_valid),
    .tf_ready (tf_ready),
    .state    (state)
  );

  // Driver/collector: t counts cycles from the one where start is high; sampled at negedges.
  task automatic run_job(input logic [8:0] b, input logic [9:0] c, input int mode,
                         input int extra_t, input int rst_word);
    int outst;
    got_q.delete(); got_t.delete(); addr_q.delete();
    en_cnt = 0; max_out = 0; done_t = -1; outst = 0;
    busy_t1 = 1'b0; busy_at_done = 1'b1; state_t2 = 2'd3;
    for (int t = 0; t < 400; t++) begin
      start    = (t == 0) || (t == extra_t);
      base     = (t == 0) ? b : 9'd200;
      count    = (t == 0) ? c : 10'd2;
      tf_ready = (mode == 0) || (t % 3 == 0);
      if (t == 1) busy_t1 = busy;
      if (t == 2) state_t2 = state;
      if (rom_EN) begin
        en_cnt++;
        addr_q.push_back(rom_A);
        outst++;
        if (outst > max_out) max_out = outst;
      end
      if (tf_valid && tf_ready) begin
        got_q.push_back(tf_data);
        got_t.push_back(t);
        outst--;
      end
      if (done) begin
        done_t = t;
        busy_at_done = busy;
      end
      if (rst_word > 0 && got_q.size() == rst_word) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        break;
      end
      if (done) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; tf_ready = 1'b0; base = '0; count = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rom_EN !== 1'b0) begin errors++; $display("FAIL reset_rom_EN: got %b expected 0", rom_EN); end
    checks++; if (tf_valid !== 1'b0) begin errors++; $display("FAIL reset_tf_valid: got %b expected 0", tf_valid); end
    checks++; if (rom_A !== 9'd0) begin errors++; $display("FAIL reset_rom_A: got %0d expected 0", rom_A); end
    checks++; if (tf_data !== 56'd0) begin errors++; $display("FAIL reset_tf_data: got %h expected 0", tf_data); end
    checks++; if (rom_REN !== 1'b1) begin errors++; $display("FAIL reset_rom_REN: got %b expected 1", rom_REN); end
    checks++; if (rom_D !== 56'd0) begin errors++; $display("FAIL reset_rom_D: got %h expected 0", rom_D); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream;
    run_job(9'd0, 10'd8, 0, -1, 0);
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stream_words: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== 56'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got_q[i], 56'(i)); end
        checks++; if (got_t[i] != 3 + i) begin errors++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, got_t[i], 3 + i); end
      end
    end
    checks++; if (done_t != 11) begin errors++; $display("FAIL stream_done_cycle: got %0d expected 11", done_t); end
    checks++; if (en_cnt != 8) begin errors++; $display("FAIL stream_rom_EN_pulses: got %0d expected 8", en_cnt); end
    checks++; if (busy_t1 !== 1'b1) begin errors++; $display("FAIL stream_busy_rise: got %b expected 1", busy_t1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL stream_busy_at_done: got %b expected 0", busy_at_done); end
    checks++; if (state_t2 !== 2'd1) begin errors++; $display("FAIL stream_state_run: got %0d expected 1", state_t2); end
  endtask

  task automatic test_wrap;
    logic [8:0] exp_a [6];
    exp_a = '{9'd380, 9'd381, 9'd382, 9'd0, 9'd1, 9'd2};
    run_job(9'd380, 10'd6, 0, -1, 0);
    checks++; if (en_cnt != 6) begin errors++; $display("FAIL wrap_rom_EN_pulses: got %0d expected 6", en_cnt); end
    for (int i = 0; i < 6; i++) begin
      if (i < addr_q.size()) begin
        checks++; if (addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr_q[i], exp_a[i]); end
      end
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== ram[exp_a[i]]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_q[i], ram[exp_a[i]]); end
      end
    end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL wrap_words: got %0d expected 6", got_q.size()); end
  endtask

  task automatic test_backpressure;
    run_job(9'd10, 10'd16, 1, -1, 0);
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL bp_words: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== ram[10 + i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], ram[10 + i]); end
      end
    end
    checks++; if (en_cnt != 16) begin errors++; $display("FAIL bp_rom_EN_pulses: got %0d expected 16", en_cnt); end
    checks++; if (max_out > 4) begin errors++; $display("FAIL bp_outstanding: got %0d expected <= 4", max_out); end
    checks++; if (done_t < 0) begin errors++; $display("FAIL bp_done: got none expected pulse"); end
  endtask

  task automatic test_zero_and_busy_start;
    run_job(9'd5, 10'd0, 0, -1, 0);
    checks++; if (done_t != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_t); end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL zero_rom_EN_pulses: got %0d expected 0", en_cnt); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_words: got %0d expected 0", got_q.size()); end
    @(negedge clk);
    run_job(9'd20, 10'd10, 0, 4, 0);
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL busy_start_words: got %0d expected 10", got_q.size()); end
    checks++; if (en_cnt != 10) begin errors++; $display("FAIL busy_start_rom_EN_pulses: got %0d expected 10", en_cnt); end
    for (int i = 0; i < 10; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== ram[20 + i]) begin errors++; $display("FAIL busy_start_data[%0d]: got %h expected %h", i, got_q[i], ram[20 + i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    run_job(9'd50, 10'd20, 0, -1, 5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (rom_EN !== 1'b0) begin errors++; $display("FAIL midrst_rom_EN: got %b expected 0", rom_EN); end
    checks++; if (tf_valid !== 1'b0) begin errors++; $display("FAIL midrst_tf_valid: got %b expected 0", tf_valid); end
    checks++; if (rom_A !== 9'd0) begin errors++; $display("FAIL midrst_rom_A: got %0d expected 0", rom_A); end
    checks++; if (tf_data !== 56'd0) begin errors++; $display("FAIL midrst_tf_data: got %h expected 0", tf_data); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", state); end
    rst = 1'b0;
    run_job(9'd7, 10'd3, 0, -1, 0);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL restart_words: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== ram[7 + i]) begin errors++; $display("FAIL restart_data[%0d]: got %h expected %h", i, got_q[i], ram[7 + i]); end
      end
    end
    checks++; if (done_t != 6) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 6", done_t); end
  endtask

  task automatic test_lanes;
    logic [13:0] l;
    ram[0] = {14'd3, 14'd2, 14'd1, 14'd0};
    @(negedge clk);
    run_job(9'd0, 10'd1, 0, -1, 0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL lanes_words: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        l = lane(got_q[0], i);
        checks++; if (l !== 14'(i)) begin errors++; $display("FAIL lane[%0d]: got %0d expected %0d", i, l, i); end
      end
    end
    checks++; if (done_t != 4) begin errors++; $display("FAIL lanes_done_cycle: got %0d expected 4", done_t); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 56'(i);
    rst = 1'b1; start = 1'b0; base = '0; count = '0; tf_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    @(negedge clk);
    test_wrap();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_zero_and_busy_start();
    @(negedge clk);
    test_reset_mid();
    @(negedge clk);
    test_lanes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tf_fetch.md
# tf_fetch

Read-side client of the twiddle-factor block RAM in the radix-2, 4-BFU NTT datapath. On a start pulse it streams `count` consecutive twiddle words from the RAM, starting at `base` and wrapping modulo `DEPTH`. It absorbs the RAM's 1-cycle registered read latency and delivers words on a valid/ready stream to the butterfly array. Each word packs four 14-bit twiddles, one per BFU; lane i occupies bits [14i+13:14i].

## Interface

Parameters:

- `ADDR_W`, 9, RAM address width
- `DATA_W`, 56, word width (4 lanes × 14 bits)
- `DEPTH`, 383, RAM depth; valid addresses are 0..DEPTH-1
- `CNT_W`, 10, width of `count`

Ports:

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base`  in  ADDR_W  first address; requires base < DEPTH
- `count`  in  CNT_W  number of words to stream
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse after the last word is accepted
- `rom_A`  out  ADDR_W  RAM address (registered)
- `rom_D`  out  DATA_W  RAM write data; tied to 0
- `rom_EN`  out  1  RAM enable (registered); high only on cycles that issue a read
- `rom_REN`  out  1  RAM read select; constant 1, so this block never writes
- `rom_Q`  in  DATA_W  RAM read data; valid the cycle after `rom_EN`
- `tf_data`  out  DATA_W  head-of-FIFO twiddle word
- `tf_valid`  out  1  `tf_data` is valid
- `tf_ready`  in  1  consumer accepts; transfer when `tf_valid & tf_ready`

## Operation

- FSM states:
  - IDLE: on `start`, latch base and count. Go to RUN if count ≠ 0; otherwise go back to IDLE with `done` pulsed next cycle, issuing no reads.
  - RUN: issue reads until `issued == count`, then go to DRAIN.
  - DRAIN: wait until every issued word has been accepted, then pulse `done` and go to IDLE.
- Address generator:
  - Starts at `base`, incremented once per issued read.
  - On the cycle after A = DEPTH-1 it becomes 0. There is no modular arithmetic wider than ADDR_W+1.
- Output buffer is a 4-entry FIFO.
- Credit rule for issuing a read: `fifo_cnt + inflight < 4`, where `inflight` is the number of reads issued whose data is not yet pushed (0..2).
  - This guarantees the FIFO never overflows.
  - This sustains 1 word/cycle when `tf_ready` is held high.
- Read-data capture:
  - A 1-bit pipeline flag marks the cycle in which `rom_Q` holds fresh data.
  - `rom_Q` is pushed only when that flag is set. Because `rom_EN` low holds the RAM output, stale data must not be re-pushed.
- Simultaneous push and pop with the FIFO full is legal (count unchanged). A pop with the FIFO empty cannot happen, since `tf_valid` is 0.
- `start` while busy is ignored; latched base and count are unchanged.
- `rst` mid-operation clears everything to the reset state the next cycle. In-flight RAM data is discarded.
- Reset values: state IDLE; `busy`, `done`, `rom_EN`, `tf_valid` = 0; `rom_A` = 0; FIFO empty; `tf_data` = 0; `rom_REN` = 1; `rom_D` = 0.

## Timing

- Cycle 0: `start` sampled.
- Cycle 1: `rom_EN` = 1, `rom_A` = base.
- Cycle 2: `rom_Q` valid; word pushed at end of cycle.
- Cycle 3: `tf_valid` = 1.
- Latency from start to first `tf_valid` is 3 cycles.
- With `tf_ready` held high, words stream back-to-back. The last word appears at cycle count+2, and `done` pulses the cycle after it is accepted.
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- When backpressure releases, issuing resumes the cycle after the credit frees.

## Structure

- Shared package `tf_pkg` holds:
  - `LANE_W` = 14, `LANES` = 4, `DATA_W`, `ADDR_W`, `DEPTH`
  - the FSM state enum {IDLE, RUN, DRAIN}
  - a lane-extract function
- Sub-module `tf_fifo4`: 4-entry synchronous FIFO with count, push/pop, and `empty`/`full` outputs. It is also reusable for other RAM-latency buffers.
- The top level holds the FSM, address/issue counters, credit logic and RAM pipeline flag. Target is about 200 lines of RTL.

## Test plan

- Stream, no backpressure: base=0, count=8, RAM[i]=i, `tf_ready`=1 → `tf_data` 0..7 on cycles 3..10; `done` pulses at cycle 11; exactly 8 `rom_EN` pulses.
- Wrap-around: base=380, count=6 → addresses 380, 381, 382, 0, 1, 2 in order; data matches.
- Backpressure: count=16 with `tf_ready` toggling 1,0,0,1,… → no loss or duplication; `rom_EN` is never high when `fifo_cnt + inflight` = 4; FIFO count ≤ 4.
- Zero count and busy start: count=0 → `done` at cycle 1 and no `rom_EN`; a second `start` during a 10-word run is ignored (still exactly 10 words).
- Reset mid-run: `rst` during word 5 of 20 → next cycle all outputs at reset values and `tf_valid` = 0; a new start with base=7, count=3 streams RAM[7..9] correctly.
- Lane packing: RAM[0] = {14'd3, 14'd2, 14'd1, 14'd0} → lane i of `tf_data` equals i.
